// File: rtl/msg_schedule_gen.sv
// msg_schedule_gen
// SHA-2 message-schedule generator. Holds a 16-word sliding window loaded
// from a message block and streams W_0..W_(ROUNDS-1) to the round core.
// MODE_512=0 selects SHA-256 (32-bit words, 64 rounds), 1 selects SHA-512
// (64-bit words, 80 rounds).
//
// Ports:
//   clk      rising-edge clock
//   reset    synchronous active-high reset
//   load     capture `block` and start a new schedule (any state)
//   block    message block, word 0 in the MSBs
//   w_ready  round core accepts the current word
//   w_valid  w_data holds schedule word w_index
//   w_data   current schedule word W_t (window register win[0])
//   w_index  t of w_data
//   busy     schedule active (FSM state: 1 = ACTIVE, 0 = IDLE)
//   done     one-cycle pulse after W_(ROUNDS-1) is accepted
//
// Handshake: a word transfers on a rising edge where w_valid=1 and
// w_ready=1 (and load=0). While w_valid=1 and w_ready=0, w_data and
// w_index hold. w_valid never depends combinationally on w_ready.
module msg_schedule_gen #(
  parameter bit  MODE_512 = 1'b0,
  localparam int WORD_W   = MODE_512 ? 64 : 32,
  localparam int ROUNDS   = MODE_512 ? 80 : 64,
  localparam int BLOCK_W  = 16 * WORD_W,
  localparam int IDX_W    = 7
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [BLOCK_W-1:0] block,
  input  logic               w_ready,
  output logic               w_valid,
  output logic [WORD_W-1:0]  w_data,
  output logic [IDX_W-1:0]   w_index,
  output logic               busy,
  output logic               done
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACTIVE = 1'b1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROUNDS - 1);

  logic [0:0]        state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic              done_q, done_d;
  logic [WORD_W-1:0] win_q [16];
  logic [WORD_W-1:0] win_d [16];

  logic              accept;
  logic [WORD_W-1:0] s0, s1, wnew;

  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x,
                                             input int unsigned n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  function automatic logic [WORD_W-1:0] sigma0(input logic [WORD_W-1:0] x);
    if (MODE_512) return rotr(x, 1) ^ rotr(x, 8) ^ (x >> 7);
    else          return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [WORD_W-1:0] sigma1(input logic [WORD_W-1:0] x);
    if (MODE_512) return rotr(x, 19) ^ rotr(x, 61) ^ (x >> 6);
    else          return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // Window positions relative to the word being produced, W_(t+16):
  // win[14]=W_(t+14), win[9]=W_(t+9), win[1]=W_(t+1), win[0]=W_t.
  assign s0   = sigma0(win_q[1]);
  assign s1   = sigma1(win_q[14]);
  assign wnew = s1 + win_q[9] + s0 + win_q[0];

  // load wins over an accept in the same cycle: the in-flight word is dropped.
  assign accept = (state_q == ACTIVE) && w_ready && !load;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    for (int i = 0; i < 16; i++) win_d[i] = win_q[i];

    if (load) begin
      for (int i = 0; i < 16; i++) win_d[i] = block[BLOCK_W-1-i*WORD_W -: WORD_W];
      cnt_d   = '0;
      state_d = ACTIVE;
    end else if (accept) begin
      for (int i = 0; i < 15; i++) win_d[i] = win_q[i+1];
      win_d[15] = wnew;
      // The terminal accept still shifts the window but parks the counter
      // at ROUNDS-1 until the next load.
      if (cnt_q == LAST_IDX) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      for (int i = 0; i < 16; i++) win_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      for (int i = 0; i < 16; i++) win_q[i] <= win_d[i];
    end
  end

  assign w_valid = (state_q == ACTIVE);
  assign busy    = (state_q == ACTIVE);
  assign w_data  = win_q[0];
  assign w_index = cnt_q;
  assign done    = done_q;

endmodule

// File: tb/tb_msg_schedule_gen.sv
// tb_msg_schedule_gen
// Bench for msg_schedule_gen. One instance per mode (SHA-256 and SHA-512)
// share clock and reset. A reference schedule is computed from the loaded
// block and pushed to an expected queue; accepted words are popped and
// compared. Inputs change on the falling edge, outputs are sampled there.
module tb_msg_schedule_gen;

  localparam int W = 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  // ---------------- DUT signals ----------------
  logic         load256, ready256, valid256, busy256, done256;
  logic [511:0] block256;
  logic [31:0]  data256;
  logic [6:0]   idx256;

  logic          load512, ready512, valid512, busy512, done512;
  logic [1023:0] block512;
  logic [63:0]   data512;
  logic [6:0]    idx512;

  msg_schedule_gen #(.MODE_512(1'b0)) dut256 (
    .clk(clk), .reset(reset), .load(load256), .block(block256),
    .w_ready(ready256), .w_valid(valid256), .w_data(data256),
    .w_index(idx256), .busy(busy256), .done(done256)
  );

  msg_schedule_gen #(.MODE_512(1'b1)) dut512 (
    .clk(clk), .reset(reset), .load(load512), .block(block512),
    .w_ready(ready512), .w_valid(valid512), .w_data(data512),
    .w_index(idx512), .busy(busy512), .done(done512)
  );

  // Observed view of whichever instance is under test
  logic         sel512;
  logic         o_valid, o_busy, o_done;
  logic [63:0]  o_data;
  logic [6:0]   o_idx;

  always_comb begin
    o_valid = sel512 ? valid512 : valid256;
    o_busy  = sel512 ? busy512  : busy256;
    o_done  = sel512 ? done512  : done256;
    o_data  = sel512 ? data512  : {32'b0, data256};
    o_idx   = sel512 ? idx512   : idx256;
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int           idx_q[$];
  logic [63:0]  blk_a [16];
  logic [63:0]  blk_b [16];
  logic [63:0]  sched [80];
  logic [63:0]  got   [80];
  logic [63:0]  ref_got [80];
  int errors = 0;
  int checks = 0;

  // ---------------- reference model ----------------
  function automatic logic [31:0] r32(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [63:0] r64(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  task automatic build_model(input int which);
    int rounds;
    logic [31:0] a32;
    logic [63:0] a64;
    rounds = sel512 ? 80 : 64;
    for (int t = 0; t < 16; t++) begin
      a64 = (which != 0) ? blk_b[t] : blk_a[t];
      sched[t] = sel512 ? a64 : {32'b0, a64[31:0]};
    end
    for (int t = 16; t < rounds; t++) begin
      if (sel512) begin
        a64 = (r64(sched[t-2], 19) ^ r64(sched[t-2], 61) ^ (sched[t-2] >> 6))
            + sched[t-7]
            + (r64(sched[t-15], 1) ^ r64(sched[t-15], 8) ^ (sched[t-15] >> 7))
            + sched[t-16];
        sched[t] = a64;
      end else begin
        a32 = (r32(sched[t-2][31:0], 17) ^ r32(sched[t-2][31:0], 19) ^ (sched[t-2][31:0] >> 10))
            + sched[t-7][31:0]
            + (r32(sched[t-15][31:0], 7) ^ r32(sched[t-15][31:0], 18) ^ (sched[t-15][31:0] >> 3))
            + sched[t-16][31:0];
        sched[t] = {32'b0, a32};
      end
    end
    exp_q.delete();
    idx_q.delete();
    for (int t = 0; t < rounds; t++) begin
      exp_q.push_back(sched[t]);
      idx_q.push_back(t);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_inputs(input logic ld, input logic rdy);
    load256  = sel512 ? 1'b0 : ld;
    ready256 = sel512 ? 1'b0 : rdy;
    load512  = sel512 ? ld : 1'b0;
    ready512 = sel512 ? rdy : 1'b0;
  endtask

  task automatic set_block(input int which);
    logic [63:0] w;
    for (int i = 0; i < 16; i++) begin
      w = (which != 0) ? blk_b[i] : blk_a[i];
      block256[511-32*i -: 32]  = w[31:0];
      block512[1023-64*i -: 64] = w;
    end
  endtask

  task automatic abc_block();
    for (int i = 0; i < 16; i++) blk_a[i] = 64'h0;
    blk_a[0]  = sel512 ? 64'h6162638000000000 : 64'h0000000061626380;
    blk_a[15] = 64'h18;
  endtask

  task automatic random_block(input int which);
    for (int i = 0; i < 16; i++) begin
      if (which != 0) blk_b[i] = {$urandom, $urandom};
      else            blk_a[i] = {$urandom, $urandom};
    end
  endtask

  // Loads blk_a and streams it. stall_pct: chance of w_ready=0 per cycle.
  // reload_at>=0: load blk_b when that index is showing. btb: load blk_b in
  // the cycle done is high. Called on a falling edge.
  task automatic run_stream(input string name, input int stall_pct,
                            input int reload_at, input bit btb,
                            input int exp_dones);
    int rounds, since_load, done_cnt, tail, ei;
    bit after_load, reloaded, pv, pr, ld;
    logic rdy;
    logic [63:0] pd, e;
    logic [6:0]  pi;
    rounds = sel512 ? 80 : 64;
    for (int t = 0; t < 80; t++) got[t] = 64'hBAD0_BAD0_BAD0_BAD0;
    set_block(0);
    build_model(0);
    set_inputs(1'b1, 1'b1);
    since_load = 0; after_load = 1'b1; done_cnt = 0; reloaded = 1'b0;
    pv = 1'b0; pr = 1'b1; pd = '0; pi = '0; tail = -1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      since_load++;
      ld = 1'b0;
      if (pv && !pr) begin
        checks++;
        if (o_valid !== 1'b1 || o_data !== pd || o_idx !== pi)
          $display("FAIL %s stall_hold: got v=%b d=%h i=%0d expected v=1 d=%h i=%0d",
                   name, o_valid, o_data, o_idx, pd, pi);
        if (o_valid !== 1'b1 || o_data !== pd || o_idx !== pi) errors++;
      end
      if (after_load) begin
        checks++;
        if (o_valid !== 1'b1 || o_busy !== 1'b1 || o_idx !== 7'd0) begin
          errors++;
          $display("FAIL %s load_latency: got v=%b busy=%b i=%0d expected v=1 busy=1 i=0",
                   name, o_valid, o_busy, o_idx);
        end
        after_load = 1'b0;
      end
      if (o_done === 1'b1) begin
        done_cnt++;
        if (stall_pct == 0) begin
          checks++;
          if (since_load != rounds + 1) begin
            errors++;
            $display("FAIL %s done_latency: got %0d cycles expected %0d", name, since_load, rounds + 1);
          end
        end
        checks++;
        if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_idx !== 7'(rounds - 1)) begin
          errors++;
          $display("FAIL %s done_state: got v=%b busy=%b i=%0d expected v=0 busy=0 i=%0d",
                   name, o_valid, o_busy, o_idx, rounds - 1);
        end
        if (btb && done_cnt == 1) begin
          set_block(1); build_model(1); ld = 1'b1;
        end
      end
      if (!ld && reload_at >= 0 && !reloaded && o_valid === 1'b1 && o_idx == 7'(reload_at)) begin
        set_block(1); build_model(1); ld = 1'b1; reloaded = 1'b1;
      end
      rdy = (stall_pct == 0) ? 1'b1 : ($urandom_range(0, 99) >= stall_pct);
      if (ld) begin
        rdy = 1'b1; since_load = 0; after_load = 1'b1;
      end else if (o_valid === 1'b1 && rdy) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL %s extra_word: got i=%0d d=%h expected no word", name, o_idx, o_data);
        end else begin
          e = exp_q.pop_front();
          ei = idx_q.pop_front();
          if (o_data !== e || o_idx !== 7'(ei)) begin
            errors++;
            $display("FAIL %s word: got i=%0d d=%h expected i=%0d d=%h", name, o_idx, o_data, ei, e);
          end
          got[ei] = o_data;
        end
      end
      pv = (o_valid === 1'b1); pr = rdy || ld; pd = o_data; pi = o_idx;
      set_inputs(ld, rdy);
      if (tail > 0) begin
        tail--;
        if (tail == 0) break;
      end else if (tail < 0 && done_cnt >= exp_dones) begin
        tail = 3;
      end
    end
    set_inputs(1'b0, 1'b0);
    checks++;
    if (done_cnt != exp_dones) begin
      errors++;
      $display("FAIL %s done_count: got %0d expected %0d", name, done_cnt, exp_dones);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s words_left: got %0d expected 0", name, exp_q.size());
    end
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (valid256 !== 1'b0 || busy256 !== 1'b0 || done256 !== 1'b0 ||
        data256 !== 32'h0 || idx256 !== 7'h0) begin
      errors++;
      $display("FAIL %s sha256: got v=%b b=%b dn=%b d=%h i=%0d expected all 0",
               name, valid256, busy256, done256, data256, idx256);
    end
    checks++;
    if (valid512 !== 1'b0 || busy512 !== 1'b0 || done512 !== 1'b0 ||
        data512 !== 64'h0 || idx512 !== 7'h0) begin
      errors++;
      $display("FAIL %s sha512: got v=%b b=%b dn=%b d=%h i=%0d expected all 0",
               name, valid512, busy512, done512, data512, idx512);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    sel512 = 1'b0;
    set_inputs(1'b0, 1'b1);
    block256 = '0; block512 = '0;
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("reset_init");
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    // w_ready high in IDLE must be ignored
    check_reset_outputs("idle_ignores_ready");
  endtask

  task automatic test_abc256();
    sel512 = 1'b0;
    abc_block();
    run_stream("abc256", 0, -1, 1'b0, 1);
    checks++;
    if (got[16] !== 64'h61626380 || got[17] !== 64'h000F0000 || got[18] !== 64'h7DA86405) begin
      errors++;
      $display("FAIL abc256_vectors: got %h %h %h expected 61626380 000f0000 7da86405",
               got[16], got[17], got[18]);
    end
    for (int t = 0; t < 80; t++) ref_got[t] = got[t];
  endtask

  task automatic test_random_stalls();
    int diffs;
    sel512 = 1'b0;
    abc_block();
    run_stream("stall256", 40, -1, 1'b0, 1);
    diffs = 0;
    for (int t = 0; t < 64; t++) if (got[t] !== ref_got[t]) diffs++;
    checks++;
    if (diffs != 0) begin
      errors++;
      $display("FAIL stall_sequence: got %0d differing words expected 0", diffs);
    end
  endtask

  task automatic test_reload();
    sel512 = 1'b0;
    random_block(0);
    random_block(1);
    run_stream("reload256", 0, 30, 1'b0, 1);
  endtask

  task automatic test_back_to_back();
    sel512 = 1'b0;
    random_block(0);
    random_block(1);
    run_stream("btb256", 0, -1, 1'b1, 2);
  endtask

  task automatic test_abc512();
    sel512 = 1'b1;
    abc_block();
    run_stream("abc512", 0, -1, 1'b0, 1);
    checks++;
    if (got[16] !== 64'h6162638000000000 || got[17] !== 64'h00030000000000C0) begin
      errors++;
      $display("FAIL abc512_vectors: got %h %h expected 6162638000000000 00030000000000c0",
               got[16], got[17]);
    end
    random_block(0);
    run_stream("rand512_stall", 30, -1, 1'b0, 1);
  endtask

  task automatic test_reset_mid();
    sel512 = 1'b0;
    random_block(0);
    set_block(0);
    set_inputs(1'b1, 1'b1);
    @(negedge clk);
    set_inputs(1'b0, 1'b1);
    for (int i = 0; i < 10; i++) @(negedge clk);
    // reset together with a load: reset must win
    reset = 1'b1;
    set_inputs(1'b1, 1'b1);
    @(negedge clk);
    check_reset_outputs("reset_mid_1");
    @(negedge clk);
    check_reset_outputs("reset_mid_2");
    reset = 1'b0;
    set_inputs(1'b0, 1'b1);
    @(negedge clk);
    check_reset_outputs("reset_release");
  endtask

  // ---------------- main ----------------
  initial begin
    test_reset();
    test_abc256();
    test_random_stalls();
    test_reload();
    test_back_to_back();
    test_abc512();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
